sevenseg_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment scanner, successor to the fixed 8-digit scan logic in the board top.

---
 rtl/sevenseg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow latching,
// leading-zero blanking, per-digit enable, decimal points and PWM brightness.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 500,
  parameter int PWM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sev_out,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]        div_cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [PWM_BITS-1:0]     pwm_cnt_q;
  logic                    load_pending_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q;
  logic [NUM_DIGITS-1:0]   sh_en_q;
  logic                    sh_blz_q;
  logic [NUM_DIGITS-1:0]   an_q,  an_d;
  logic [6:0]              sev_q, sev_d;
  logic                    dp_n_q, dp_n_d;
  logic                    fs_q,  fs_d;

  logic                    tick;
  logic                    frame_end;
  logic                    lit;
  logic                    anode_on;
  logic [4*NUM_DIGITS-1:0] eff_data;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic                    eff_blz;
  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  assign tick      = (div_cnt_q == LAST_DIV);
  assign frame_end = tick & (idx_q == LAST_IDX);

  // While a load is pending the shadow is being filled this very cycle, so
  // the output stage sees the incoming values instead of stale contents.
  assign eff_data = load_pending_q ? data     : sh_data_q;
  assign eff_dp   = load_pending_q ? dp       : sh_dp_q;
  assign eff_en   = load_pending_q ? digit_en : sh_en_q;
  assign eff_blz  = load_pending_q ? blank_lz : sh_blz_q;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = eff_data[4*gi +: 4];
    if (gi == 0) begin : g_first
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = eff_blz & (eff_data[4*NUM_DIGITS-1:4*gi] == '0);
    end
  end

  assign lit      = (&brightness) | (pwm_cnt_q < brightness);
  assign anode_on = eff_en[idx_q] & lit;

  always_comb begin
    an_d         = '1;
    an_d[idx_q]  = ~anode_on;
    sev_d        = (anode_on & ~blank[idx_q]) ? hex_to_seg(nib[idx_q]) : 7'h7F;
    dp_n_d       = ~(eff_dp[idx_q] & anode_on);
    fs_d         = (idx_q == '0) & (div_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      div_cnt_q      <= '0;
      idx_q          <= '0;
      pwm_cnt_q      <= '0;
      load_pending_q <= 1'b1;
      sh_data_q      <= '0;
      sh_dp_q        <= '0;
      sh_en_q        <= '0;
      sh_blz_q       <= 1'b0;
      an_q           <= '1;
      sev_q          <= 7'h7F;
      dp_n_q         <= 1'b1;
      fs_q           <= 1'b0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (load_pending_q | frame_end) begin
        sh_data_q      <= data;
        sh_dp_q        <= dp;
        sh_en_q        <= digit_en;
        sh_blz_q       <= blank_lz;
        load_pending_q <= 1'b0;
      end
      an_q   <= an_d;
      sev_q  <= sev_d;
      dp_n_q <= dp_n_d;
      fs_q   <= fs_d;
    end
  end

  assign an          = an_q;
  assign sev_out     = sev_q;
  assign dp_n        = dp_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: cycle-count based reference model checked
// every cycle, plus hand-computed literal expectations at known slots.
module tb_sevenseg_scan_ctrl;
  localparam int N     = 4;
  localparam int D     = 4;
  localparam int PB    = 2;
  localparam int FRAME = N * D;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = '0;
  logic [3:0]  an;
  logic [6:0]  sev_out;
  logic        dp_n;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(D), .PWM_BITS(PB)) dut (
    .clk(clk), .Rst(Rst), .data(data), .dp(dp), .digit_en(digit_en),
    .blank_lz(blank_lz), .brightness(brightness), .an(an), .sev_out(sev_out),
    .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: everything derives from the number of clocks since reset
  // released; the shadow is a snapshot of the inputs at each frame boundary.
  bit          m_valid = 1'b0;
  bit          m_pend;
  int          m_cnt;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_en;
  bit          m_blz;
  logic [3:0]  e_an;
  logic [6:0]  e_sev;
  logic        e_dp, e_fs;

  always @(posedge clk) begin : model
    int idx, pwm;
    bit on, blk, lit;
    logic [3:0] nib;
    if (Rst) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_pend  = 1'b1;
      e_an    = 4'hF;
      e_sev   = 7'h7F;
      e_dp    = 1'b1;
      e_fs    = 1'b0;
    end else begin
      if (m_pend) begin
        m_data = data; m_dp = dp; m_en = digit_en; m_blz = blank_lz;
      end
      idx   = (m_cnt / D) % N;
      pwm   = m_cnt % (1 << PB);
      lit   = (brightness == 2'b11) || (pwm < int'(brightness));
      on    = m_en[idx] && lit;
      nib   = 4'((m_data >> (4 * idx)) & 16'hF);
      blk   = m_blz && (idx != 0) && ((m_data >> (4 * idx)) == 16'h0);
      e_an  = 4'hF;
      if (on) e_an[idx] = 1'b0;
      e_sev = (on && !blk) ? seg_tab[nib] : 7'h7F;
      e_dp  = !(m_dp[idx] && on);
      e_fs  = (m_cnt % FRAME) == 0;
      if (!m_pend && (m_cnt % FRAME) == FRAME - 1) begin
        m_data = data; m_dp = dp; m_en = digit_en; m_blz = blank_lz;
      end
      m_pend = 1'b0;
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (an !== e_an || sev_out !== e_sev || dp_n !== e_dp || frame_start !== e_fs) begin
        errors++;
        $display("FAIL model t=%0t an=%h/%h sev=%b/%b dp_n=%b/%b fs=%b/%b (got/expected)",
                 $time, an, e_an, sev_out, e_sev, dp_n, e_dp, frame_start, e_fs);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 ns after the first clock edge with reset released.
  task automatic restart();
    Rst = 1'b1;
    tick(2);
    Rst = 1'b0;
    tick(1);
  endtask

  initial begin
    // 1: basic scan order, patterns, frame_start period
    data = 16'h1234; digit_en = 4'hF; dp = 4'h0; blank_lz = 1'b0; brightness = 2'd3;
    tick(3);
    Rst = 1'b0;
    tick(1);
    chk("t1_an_d0", 16'(an), 16'hE);
    chk("t1_fs_d0", 16'(frame_start), 16'h1);
    chk("t1_sev_d0", 16'(sev_out), 16'(7'b1001100));
    tick(1);
    chk("t1_fs_off", 16'(frame_start), 16'h0);
    tick(3);
    chk("t1_an_d1", 16'(an), 16'hD);
    chk("t1_sev_d1", 16'(sev_out), 16'(7'b0000110));
    tick(8);
    chk("t1_an_d3", 16'(an), 16'h7);
    chk("t1_sev_d3", 16'(sev_out), 16'(7'b1001111));
    tick(4);
    chk("t1_fs_frame2", 16'(frame_start), 16'h1);
    chk("t1_an_frame2", 16'(an), 16'hE);

    // 2: leading-zero blanking on/off
    data = 16'h0050; blank_lz = 1'b1;
    restart();
    chk("t2_sev_d0", 16'(sev_out), 16'(7'b0000001));
    tick(4);
    chk("t2_sev_d1", 16'(sev_out), 16'(7'b0100100));
    tick(4);
    chk("t2_sev_d2_blank", 16'(sev_out), 16'h7F);
    tick(4);
    chk("t2_sev_d3_blank", 16'(sev_out), 16'h7F);
    chk("t2_an_d3", 16'(an), 16'h7);
    blank_lz = 1'b0;
    restart();
    tick(8);
    chk("t2_sev_d2_shown", 16'(sev_out), 16'(7'b0000001));
    tick(4);
    chk("t2_sev_d3_shown", 16'(sev_out), 16'(7'b0000001));

    // 3: mid-frame data change waits for the frame boundary
    data = 16'h1111;
    restart();
    tick(4);
    data = 16'h2222;
    tick(4);
    chk("t3_d2_old", 16'(sev_out), 16'(7'b1001111));
    tick(4);
    chk("t3_d3_old", 16'(sev_out), 16'(7'b1001111));
    tick(4);
    chk("t3_d0_new", 16'(sev_out), 16'(7'b0010010));

    // 4: brightness duty, applied immediately
    data = 16'h1234; brightness = 2'd1;
    restart();
    chk("t4_b1_on", 16'(an), 16'hE);
    tick(1);
    chk("t4_b1_off", 16'(an), 16'hF);
    tick(3);
    chk("t4_b1_d1_on", 16'(an), 16'hD);
    brightness = 2'd0;
    tick(1);
    tick(1);
    chk("t4_b0_dark", 16'(an), 16'hF);
    brightness = 2'd3;
    tick(1);
    chk("t4_b3_on", 16'(an), 16'hD);
    tick(8);

    // 5: per-digit enable and decimal point
    digit_en = 4'b0101; dp = 4'b0001;
    restart();
    chk("t5_an_d0", 16'(an), 16'hE);
    chk("t5_dp_d0", 16'(dp_n), 16'h0);
    tick(4);
    chk("t5_an_d1_dark", 16'(an), 16'hF);
    chk("t5_sev_d1_dark", 16'(sev_out), 16'h7F);
    chk("t5_dp_d1", 16'(dp_n), 16'h1);
    tick(4);
    chk("t5_an_d2", 16'(an), 16'hB);
    tick(8);
    chk("t5_fs_16", 16'(frame_start), 16'h1);

    // 6: reset during the digit 2 slot
    digit_en = 4'hF; dp = 4'h0;
    restart();
    tick(8);
    chk("t6_an_d2", 16'(an), 16'hB);
    Rst = 1'b1;
    tick(1);
    chk("t6_an_dark", 16'(an), 16'hF);
    chk("t6_sev_dark", 16'(sev_out), 16'h7F);
    Rst = 1'b0;
    tick(1);
    chk("t6_fs_restart", 16'(frame_start), 16'h1);
    chk("t6_an_restart", 16'(an), 16'hE);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 80; i++) begin
      data       = 16'($urandom);
      if ($urandom_range(0, 2) == 0) data = data & 16'h00FF;
      dp         = 4'($urandom);
      digit_en   = 4'($urandom);
      blank_lz   = 1'($urandom);
      brightness = 2'($urandom);
      Rst        = ($urandom_range(0, 15) == 0);
      tick($urandom_range(1, 7));
      Rst        = 1'b0;
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
